// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: accepts one shift request, applies at most STEP bit
// positions per cycle, and returns the result over a valid/ready handshake.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [WIDTH-1:0]         req_data,
    input  logic [$clog2(WIDTH):0]   req_amount,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy,
    input  logic                     flush
);

    localparam int AW = $clog2(WIDTH) + 1;
    localparam logic [AW-1:0] WIDTH_AW = AW'(WIDTH);
    localparam logic [AW-1:0] STEP_AW  = AW'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    state_e          state_q;
    op_e             op_q;
    op_e             req_op_e;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] rsp_data_q;
    logic [AW-1:0]   rem_q;
    logic [AW-1:0]   rem_d;
    logic [AW-1:0]   k_d;
    logic [AW-1:0]   eff_d;

    // One bounded shift step; k never exceeds STEP, so this stays a narrow mux.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input op_e              op,
        input logic [AW-1:0]    k
    );
        case (op)
            OP_SRL:  return v >> k;
            OP_SRA:  return $signed(v) >>> k;
            OP_SLL:  return v << k;
            default: return (v >> k) | (v << (WIDTH_AW - k));
        endcase
    endfunction

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        req_op_e = op_e'(req_op);
        eff_d    = '0;
        if (req_op_e == OP_ROR) begin
            eff_d = {1'b0, req_amount[AW-2:0]};
        end else if (req_amount > WIDTH_AW) begin
            eff_d = WIDTH_AW;
        end else begin
            eff_d = req_amount;
        end

        k_d    = (rem_q > STEP_AW) ? STEP_AW : rem_q;
        data_d = shift_step(data_q, op_q, k_d);
        rem_d  = rem_q - k_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_SRL;
            data_q     <= '0;
            rem_q      <= '0;
            rsp_data_q <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        data_q <= req_data;
                        op_q   <= req_op_e;
                        rem_q  <= eff_d;
                        if (eff_d == '0) begin
                            state_q    <= ST_DONE;
                            rsp_data_q <= req_data;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q    <= ST_DONE;
                        rsp_data_q <= data_d;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized bench for shift_sequencer against a whole-shift
// reference model (full-width arithmetic, no per-step iteration).
module tb_shift_sequencer;

    localparam int W    = 32;
    localparam int STEP = 4;
    localparam int AW   = $clog2(W) + 1;

    localparam logic [1:0] SRL = 2'b00;
    localparam logic [1:0] SRA = 2'b01;
    localparam logic [1:0] SLL = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [W-1:0]  req_data;
    logic [AW-1:0] req_amount;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          busy;
    logic          flush;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(W), .STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_amount (req_amount),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_eff(input logic [1:0] op, input int amt);
        if (op == ROR) return amt % W;
        return (amt > W) ? W : amt;
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] d, input int amt);
        int                 eff;
        logic [2*W-1:0]     wide;
        logic signed [2*W-1:0] swide;
        eff = ref_eff(op, amt);
        case (op)
            SRL: begin wide = {{W{1'b0}}, d} >> eff; return wide[W-1:0]; end
            SRA: begin swide = $signed({{W{d[W-1]}}, d}) >>> eff; return swide[W-1:0]; end
            SLL: begin wide = {{W{1'b0}}, d} << eff; return wide[W-1:0]; end
            default: begin wide = {d, d} >> eff; return wide[W-1:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input int amt);
        int eff;
        eff = ref_eff(op, amt);
        return 1 + (eff + STEP - 1) / STEP;
    endfunction

    // Present a request at a negedge; it is accepted at the following posedge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input int amt);
        @(negedge clk);
        check("req_ready_before_accept", req_ready, 1);
        req_valid  = 1'b1;
        req_op     = op;
        req_data   = d;
        req_amount = AW'(amt);
        @(negedge clk);
        req_valid  = 1'b0;
        req_op     = 2'($urandom);
        req_data   = $urandom;
        req_amount = AW'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] d, input int amt, input int hold);
        int            lat;
        logic [W-1:0]  exp;
        exp = ref_result(op, d, amt);
        send(op, d, amt);
        wait_rsp(lat);
        check("rsp_valid", rsp_valid, 1);
        check("latency", lat, ref_latency(op, amt));
        check("rsp_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, exp);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_rsp", {req_ready, rsp_valid, busy}, 3'b100);
        check("rsp_data_retained", rsp_data, exp);
    endtask

    initial begin
        int            lat;
        logic [W-1:0]  exp1;
        logic [W-1:0]  exp2;
        logic [W-1:0]  prev;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = SRL;
        req_data   = '0;
        req_amount = '0;
        rsp_ready  = 1'b0;
        flush      = 1'b0;
        #12;
        check("reset_outputs", {req_ready, rsp_valid, busy}, 3'b100);
        check("reset_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the boundary list.
        run_op(SRA, 32'h8000_0000, 4, 0);
        run_op(SRL, 32'hFFFF_FFFF, 40, 0);
        run_op(ROR, 32'h0000_0001, 33, 0);
        run_op(SLL, 32'h0000_000F, 7, 0);
        run_op(SRA, 32'h1234_5678, 0, 5);
        run_op(SRA, 32'h8765_4321, 32, 0);
        run_op(SLL, 32'hDEAD_BEEF, 32, 0);
        run_op(ROR, 32'hA5A5_0FF0, 63, 0);

        // Back-to-back: req_valid held high with a second op queued behind the first.
        exp1 = ref_result(SLL, 32'h0000_0003, 9);
        exp2 = ref_result(SRL, 32'hF000_0000, 5);
        @(negedge clk);
        req_valid = 1'b1; req_op = SLL; req_data = 32'h0000_0003; req_amount = AW'(9);
        @(negedge clk);
        check("b2b_first_accepted", busy, 1);
        req_op = SRL; req_data = 32'hF000_0000; req_amount = AW'(5);
        rsp_ready = 1'b1;
        wait_rsp(lat);
        check("b2b_first_valid", rsp_valid, 1);
        check("b2b_first_data", rsp_data, exp1);
        @(negedge clk);
        check("b2b_gap_idle", req_ready, 1);
        @(negedge clk);
        check("b2b_second_accepted", busy, 1);
        req_valid = 1'b0;
        wait_rsp(lat);
        check("b2b_second_data", rsp_data, exp2);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("b2b_done_idle", req_ready, 1);

        // Asynchronous reset in the middle of SHIFT.
        send(SRL, 32'hFFFF_FFFF, 40);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {req_ready, rsp_valid, busy}, 3'b100);
        check("async_reset_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_rsp_after_reset", rsp_valid, 0);
        end

        // flush during SHIFT drops the operation and leaves rsp_data untouched.
        run_op(ROR, 32'h0000_00F0, 4, 0);
        prev = rsp_data;
        send(SLL, 32'h1111_1111, 32);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {req_ready, rsp_valid, busy}, 3'b100);
        check("flush_rsp_data_kept", rsp_data, prev);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_rsp_after_flush", rsp_valid, 0);
        end

        // flush wins over an accept in the same cycle.
        req_valid = 1'b1; req_op = SRL; req_data = 32'h5555_5555; req_amount = AW'(3);
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check("flush_blocks_accept", busy, 0);
        run_op(SRA, 32'hC000_0001, 13, 1);

        // Randomized operations with random response back-pressure.
        for (int n = 0; n < 60; n++) begin
            logic [1:0]   op;
            logic [W-1:0] d;
            int           amt;
            op  = 2'($urandom);
            d   = $urandom;
            amt = int'($urandom_range(0, (1 << AW) - 1));
            run_op(op, d, amt, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift engine controller for the ALU. It accepts a shift request over a valid/ready handshake and iterates the operand through a bounded per-cycle shift stage of at most STEP bits. It returns the result over a second valid/ready handshake. It replaces a single-cycle barrel shifter where area or timing matters, and supports logical right, arithmetic right, logical left and rotate right.

Parameters:
WIDTH, 32, operand width in bits; must be a power of two, >= 4.
STEP, 4, maximum bit positions shifted per SHIFT cycle; 1 <= STEP <= WIDTH.
AW (localparam), $clog2(WIDTH)+1, shift-amount width; 6 at default.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request.
req_op  in  2  00 SRL, 01 SRA, 10 SLL, 11 ROR.
req_data  in  WIDTH  operand.
req_amount  in  AW  shift amount, unsigned.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer takes result.
rsp_data  out  WIDTH  shifted result.
busy  out  1  high in SHIFT or DONE.
flush  in  1  synchronous abort to IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
  - Internal data, op and remaining-count registers are cleared.
  - Reset asserted mid-operation discards the operation; no response is ever issued for it.
- Outputs are decoded from registered state: req_ready=(state==IDLE), rsp_valid=(state==DONE), busy=(state!=IDLE).
- Effective amount (eff), computed at accept:
  - SRL/SLL/SRA: eff = min(req_amount, WIDTH). At eff=WIDTH, SRL/SLL give 0 and SRA gives all copies of the sign bit.
  - ROR: eff = req_amount mod WIDTH.
- IDLE:
  - Accept on req_valid&&req_ready: latch req_data into the working register, latch op, set remaining=eff.
  - Next state is SHIFT if eff>0, else DONE.
- SHIFT, each cycle:
  - k = min(remaining, STEP).
  - Working register shifted by k per op: SRL fills 0, SRA fills the sign bit of the current value, SLL fills 0 at the LSB, ROR rotates LSBs into MSBs.
  - remaining -= k.
  - When the post-update remaining is 0, next state is DONE.
- DONE:
  - rsp_data = working register, held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, go to IDLE. No new request is accepted in the same cycle (req_ready is 0 in DONE).
- Latency: a request accepted at edge T gives rsp_valid=1 from cycle T+1+ceil(eff/STEP). For eff=0, rsp_valid=1 at T+1.
- Throughput: at most one operation in flight. Minimum initiation interval is 2+ceil(eff/STEP) cycles with rsp_ready tied high.
- flush=1 at an edge forces IDLE from any state and drops the operation. flush takes priority over accept and over rsp handshake in the same cycle; a req_valid in a flush cycle is not accepted.
- req_data, req_op and req_amount are sampled only at accept; changes afterwards have no effect.
- rsp_data keeps its last value after returning to IDLE (reset clears it to 0).

Test Plan:
- SRA, STEP=4, req_data=0x80000000, amount=4 -> one SHIFT cycle; rsp_data=0xF8000000; rsp_valid at T+2.
- SRL, req_data=0xFFFFFFFF, amount=40 -> eff clamps to 32; 8 SHIFT cycles; rsp_data=0x00000000; rsp_valid at T+9.
- ROR, req_data=0x00000001, amount=33 -> eff=1; rsp_data=0x80000000. SLL, 0x0000000F by 7 -> 0x00000780, with ceil(7/4)=2 SHIFT cycles.
- amount=0, SRA, req_data=0x12345678 -> rsp_data=0x12345678 at T+1. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
- Back-to-back: req_valid held high with two queued ops -> second accepted exactly one cycle after the rsp handshake of the first.
- Deassert rst_n mid-SHIFT -> outputs return to reset values immediately (asynchronously). flush during SHIFT -> IDLE next edge, no rsp_valid, and the next request completes correctly.
